// File: rtl/fib_sched_arbiter.sv
// fib_sched_arbiter: one iterative Fibonacci engine shared by NUM_REQ clients.
//   A round-robin arbiter accepts one request when the engine is idle.
//   The engine computes F(n) mod 2^RES_W at one iteration per clock.
//   The result is returned with the owner's id on a valid/ready port.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_value/req_ready : per-requester request port.
//     req_ready is a combinational one-hot grant strobe.
//   rsp_valid/rsp_ready/rsp_id/rsp_data : result port.
//   busy : engine not idle.
module fib_sched_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int RES_W   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  logic [1:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [RES_W-1:0]  a, b;
  logic [DATA_W-1:0] count;

  // Round-robin pick: first valid requester at or above rr_ptr, with wrap.
  logic              found;
  logic [ID_W-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_n;
  logic [RES_W-1:0]  sum;
  int                idx;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  assign gnt_n = req_value[gnt_idx*DATA_W +: DATA_W];
  assign sum   = a + b;

  // Grant strobe exists only in IDLE; reset masks it so it reads zero
  // while reset is held, even with requests pending.
  always_comb begin
    req_ready = '0;
    if (reset && state == IDLE && found)
      req_ready[gnt_idx] = 1'b1;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      a        <= '0;
      b        <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            rsp_id <= gnt_idx;
            rr_ptr <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
            // n of 0 or 1 is its own result; skip the engine.
            if (gnt_n <= DATA_W'(1)) begin
              rsp_data <= RES_W'(gnt_n);
              state    <= RESP;
            end else begin
              a     <= '0;
              b     <= RES_W'(1);
              count <= gnt_n - DATA_W'(1);
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          // (a, b) = (F(k-1), F(k)); the last step's sum is F(n).
          a     <= b;
          b     <= sum;
          count <= count - DATA_W'(1);
          if (count == DATA_W'(1)) begin
            rsp_data <= sum;
            state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sched_arbiter.sv
// Directed self-checking bench for fib_sched_arbiter (NUM_REQ=4, DATA_W=4, RES_W=8).
module tb_fib_sched_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int RES_W   = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [1:0]                rsp_id;
  logic [RES_W-1:0]          rsp_data;
  logic                      busy;

  int tests = 0;
  int fails = 0;

  fib_sched_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request at a negedge, check the grant strobe, then wait for
  // the response. lat counts cycles after the accept cycle.
  task automatic run_job(input string tag, input int id, input int n,
                         input int exp_lat, input int exp_data);
    int lat;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_value[id*DATA_W +: DATA_W] = 4'(n);
    #1;
    chk({tag, ".grant"}, 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk({tag, ".lat"},  32'(lat), 32'(exp_lat));
    chk({tag, ".id"},   32'(rsp_id), 32'(id));
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
  endtask

  int exp_id4 [5] = '{0, 1, 2, 3, 0};
  int exp_d4  [5] = '{1, 2, 3, 5, 1};

  initial begin
    int got;
    int cyc;
    reset     = 1'b0;
    req_valid = '0;
    req_value = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rst.ready", 32'(req_ready), 0);
    chk("rst.valid", 32'(rsp_valid), 0);
    chk("rst.busy",  32'(busy), 0);
    chk("rst.id",    32'(rsp_id), 0);
    chk("rst.data",  32'(rsp_data), 0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // 1: F(10) on requester 0
    run_job("t1", 0, 10, 10, 55);
    // 2: n=0 and n=1 shortcut on requester 1
    run_job("t2a", 1, 0, 1, 0);
    run_job("t2b", 1, 1, 1, 1);
    // 3: n=15 wraps 610 -> 98
    run_job("t3", 3, 15, 15, 98);

    // 4: all requesters valid continuously; rr_ptr starts at 0 here
    @(negedge clk);
    req_value = {4'd5, 4'd4, 4'd3, 4'd2};
    req_valid = 4'b1111;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 100) begin
      #1;
      if (req_ready != 0)
        chk("t4.grant", 32'(req_ready), 32'(1 << exp_id4[got]));
      if (rsp_valid) begin
        chk("t4.id",   32'(rsp_id), 32'(exp_id4[got]));
        chk("t4.data", 32'(rsp_data), 32'(exp_d4[got]));
        got++;
      end
      if (got == 5) req_valid = '0;
      @(negedge clk);
      cyc++;
    end
    chk("t4.count", 32'(got), 5);
    req_valid = '0;

    // 5: consumer stall; rr_ptr is 1 after test 4
    rsp_ready = 1'b0;
    run_job("t5", 1, 6, 6, 8);
    req_valid[2] = 1'b1;
    req_value[2*DATA_W +: DATA_W] = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t5.valid", 32'(rsp_valid), 1);
      chk("t5.id",    32'(rsp_id), 1);
      chk("t5.data",  32'(rsp_data), 8);
      chk("t5.ready", 32'(req_ready), 0);
      chk("t5.busy",  32'(busy), 1);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("t5.idle_busy",  32'(busy), 0);
    chk("t5.idle_valid", 32'(rsp_valid), 0);

    // 6: reset mid-compute, then requester 2 after release
    run_job_start(0, 12);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    req_valid[2] = 1'b1;
    #1;
    chk("t6.valid", 32'(rsp_valid), 0);
    chk("t6.busy",  32'(busy), 0);
    chk("t6.id",    32'(rsp_id), 0);
    chk("t6.data",  32'(rsp_data), 0);
    chk("t6.ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) cyc++;
    end
    chk("t6.no_rsp", 32'(cyc), 0);
    run_job("t6b", 2, 7, 7, 13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Starts a job without waiting for its result (used to abort with reset).
  task automatic run_job_start(input int id, input int n);
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_value[id*DATA_W +: DATA_W] = 4'(n);
    #1;
    chk("t6.grant", 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

endmodule
